mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the RV32I subset core (lw, sw, R-type, I-type ALU, jal, beq/bne/blt/bge). A Moore FSM sequences the shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback, one state per clock. Combinational ALU and immediate decoders complete the block. It replaces the single-cycle control unit when the core moves to the multicycle datapath; the datapath supplies the same flags (Zero, notZero, LessThan, GreaterEqual).

## Interface
No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero, notZero, LessThan, GreaterEqual  in  1 each  ALU compare flags
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction / OldPC register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
Per-state outputs. Unlisted enables are 0; unlisted selects are 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00
- MEMREAD: AdrSrc=1, ResultSrc=00
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1
- MEMWB: ResultSrc=01, RegWrite=1
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
- ALUWB: ResultSrc=00, RegWrite=1
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1

Transitions:
- FETCH→DECODE.
- DECODE: op 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1101111 → JAL; 1100011 → BRANCH; any other op → FETCH with Illegal=1.
- MEMADR: op[5]=0 → MEMREAD, else → MEMWRITE.
- MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH.
- EXECUTER, EXECUTEI, JAL → ALUWB→FETCH. BRANCH→FETCH.

Branch condition and PC enable:
- CondBranch by funct3: 000 Zero, 001 notZero, 100 LessThan, 101 GreaterEqual, other 0.
- PCWrite = PCUpdate | (Branch & CondBranch).

Decoders:
- ALU decode: ALUOp 00 → add; 01 → sub; 10 by funct3: 000 sub if op[5]&funct7b5 else add, 010 slt, 110 or, 111 and, other add.
- ImmSrc from op only: lw and I-ALU 00, sw 01, branch 10, jal 11, other 00.

InstrDone=1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and in FETCH's successor DECODE when Illegal=1.

## Timing
- CPI: lw 5, sw 4, R/I 4, jal 4, branch 3, illegal 2.
- Outputs are Moore, decoded from the state register. ALUControl, ImmSrc and CondBranch also depend combinationally on the instruction fields.
- Reset: while reset=1, state←FETCH on each edge. PCWrite, IRWrite, RegWrite, MemWrite, InstrDone and Illegal are forced 0; selects show FETCH values.
- First fetch (IRWrite=1) occurs in the first cycle after reset deasserts.
- Reset mid-instruction aborts the instruction; no write enable is asserted in the reset cycle.
- Flags are sampled only in BRANCH. Flag values in other states must not affect PCWrite.

## Structure
- Package mc_pkg: state enum (FETCH…BRANCH), opcode constants, ALUOp encodings, ALUControl/ImmSrc/ResultSrc/ALUSrc encodings.
- Sub-module mc_mainfsm: state register, next-state logic and per-state outputs (including ALUOp, Branch, PCUpdate).
- Top level contains the ALU decoder, the immediate decoder and the PCWrite logic.

## Test plan
- Reset held 3 cycles, then released → no write enable during reset; IRWrite=1 and PCWrite=1 in the cycle after release; state FETCH→DECODE.
- lw (op 0000011) → FETCH, DECODE, MEMADR, MEMREAD, MEMWB. AdrSrc=1 in MEMREAD; RegWrite=1 with ResultSrc=01 in MEMWB; InstrDone pulses there; 5 cycles total.
- sub (op 0110011, funct3 000, funct7b5=1) → ALUControl=001 in EXECUTER; add with funct7b5=0 → 000; slt (funct3 010) → 101; ALUWB RegWrite=1.
- bne with notZero=1 → PCWrite=1 in BRANCH. bne with notZero=0 and Zero=1 → PCWrite=0. blt/bge toggled likewise; 3 cycles each.
- jal → PCWrite=1 in JAL with ALUSrcA=01, ALUSrcB=10; ALUWB writes rd; ImmSrc=11.
- op 1111111 → Illegal=1 in DECODE, next state FETCH; reset asserted during MEMWRITE → MemWrite=0 that cycle, FETCH after release.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle RV32I control unit.
//   state_t          FSM states, one per clock of an instruction
//   OP_*             supported major opcodes (Instr[6:0])
//   ALUOP_*          main-FSM request to the ALU decoder
//   ALU_*            ALUControl encodings driven to the datapath ALU
//   IMM_*            ImmSrc encodings for the immediate extender
//   RES_*            ResultSrc mux encodings
//   SRCA_* / SRCB_*  ALU operand mux encodings
//   op_supported()   true for every opcode the FSM knows how to sequence
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWRITE,
    MEMWB,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    JAL,
    BRANCH
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL)   || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: state register, next-state logic and per-state Moore outputs
// of the multicycle controller.
//   clk, reset   core clock, synchronous active-high reset
//   op           Instr[6:0] from the instruction register
//   pc_update    unconditional PC write request (FETCH, JAL)
//   branch       conditional PC write request (BRANCH)
//   adr_src, mem_write, ir_write, reg_write   datapath enables/select
//   result_src, alu_src_a, alu_src_b          datapath mux selects
//   alu_op       request to the ALU decoder
//   instr_done   pulse in the last state of every instruction
//   illegal      pulse in DECODE for an unsupported opcode
module mc_mainfsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       pc_update,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  state_t state;
  state_t cur;

  // NOTE: state is sequential, so it is only ever assigned with <=; the
  // combinational block below uses = so later lines see earlier values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    state <= DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECUTER;
            OP_ITYPE:          state <= EXECUTEI;
            OP_JAL:            state <= JAL;
            OP_BRANCH:         state <= BRANCH;
            default:           state <= FETCH;
          endcase
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        JAL:      state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // During reset the outputs already show FETCH selects, so a reset that
  // lands mid-instruction never leaves a stale memory address or mux path.
  assign cur = reset ? FETCH : state;

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a value held, which would infer a latch.
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (cur)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      DECODE: begin
        // Branch target is precomputed here into ALUOut.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        // The IR is loaded at the end of FETCH, so op is only valid from
        // DECODE onward; the illegal check therefore lives here.
        illegal    = !op_supported(op);
        instr_done = !op_supported(op);
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // No architectural write may happen in a reset cycle.
    if (reset) begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the RV32I-subset core.
//   clk, reset         core clock, synchronous active-high reset
//   op, funct3, funct7b5   instruction fields from the IR
//   Zero, notZero, LessThan, GreaterEqual   ALU compare flags
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl   datapath selects
//   InstrDone          pulse in the final state of each instruction
//   Illegal            pulse in DECODE on an unsupported opcode
// Contains the main FSM plus the ALU decoder, immediate decoder and the
// PC enable logic.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       notZero,
  input  logic       LessThan,
  input  logic       GreaterEqual,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);

  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       cond_branch;

  mc_mainfsm u_mainfsm (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .pc_update  (pc_update),
    .branch     (branch),
    .adr_src    (AdrSrc),
    .mem_write  (MemWrite),
    .ir_write   (IRWrite),
    .reg_write  (RegWrite),
    .result_src (ResultSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .alu_op     (alu_op),
    .instr_done (InstrDone),
    .illegal    (Illegal)
  );

  // ALU decoder. Subtract needs op[5] as well as funct7b5 because I-type
  // immediates reuse bit 30, so addi with a negative immediate stays add.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Immediate format depends on the opcode alone.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = IMM_I;
      OP_STORE:          ImmSrc = IMM_S;
      OP_BRANCH:         ImmSrc = IMM_B;
      OP_JAL:            ImmSrc = IMM_J;
      default:           ImmSrc = IMM_I;
    endcase
  end

  // Branch condition; only consulted when the FSM raises branch, so the
  // flags have no effect on PCWrite in any other state.
  always_comb begin
    cond_branch = 1'b0;
    case (funct3)
      3'b000:  cond_branch = Zero;
      3'b001:  cond_branch = notZero;
      3'b100:  cond_branch = LessThan;
      3'b101:  cond_branch = GreaterEqual;
      default: cond_branch = 1'b0;
    endcase
  end

  assign PCWrite = pc_update | (branch & cond_branch);

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. The stimulus
// process drives instruction fields and queues the expected output vector
// of every cycle; the monitor pops and compares on each falling edge.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, notZero, LessThan, GreaterEqual;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       InstrDone, Illegal;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       rw;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       done;
    logic       ill;
  } outs_t;

  typedef struct {
    string nm;
    outs_t v;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  outs_t act;

  mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .notZero      (notZero),
    .LessThan     (LessThan),
    .GreaterEqual (GreaterEqual),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .RegWrite     (RegWrite),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .InstrDone    (InstrDone),
    .Illegal      (Illegal)
  );

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, RegWrite, ImmSrc, ALUControl, InstrDone, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-state vectors, written out by hand from the state table.
  // Field order: pcw adr mw irw rs sa sb rw imm alu done ill
  function automatic outs_t e_reset(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_fetch(input logic [1:0] imm);
    return {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_decode(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_decode_ill(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, 1'b1, 1'b1};
  endfunction
  function automatic outs_t e_memadr(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, imm, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_memread(input logic [1:0] imm);
    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, imm, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_memwrite(input logic [1:0] imm);
    return {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, imm, 3'b000, 1'b1, 1'b0};
  endfunction
  function automatic outs_t e_memwb(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, imm, 3'b000, 1'b1, 1'b0};
  endfunction
  function automatic outs_t e_exec(input logic [1:0] srcb, input logic [1:0] imm,
                                   input logic [2:0] alu);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, srcb, 1'b0, imm, alu, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_aluwb(input logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, imm, 3'b000, 1'b1, 1'b0};
  endfunction
  function automatic outs_t e_jal();
    return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0};
  endfunction
  function automatic outs_t e_branch(input logic pcw);
    return {pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b1, 1'b0};
  endfunction

  task automatic check(input string nm, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b rw=%b imm=%b alu=%b done=%b ill=%b, expected pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b rw=%b imm=%b alu=%b done=%b ill=%b",
               nm, got.pcw, got.adr, got.mw, got.irw, got.rs, got.sa, got.sb, got.rw,
               got.imm, got.alu, got.done, got.ill, want.pcw, want.adr, want.mw,
               want.irw, want.rs, want.sa, want.sb, want.rw, want.imm, want.alu,
               want.done, want.ill);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.nm, act, e.v);
    end
  end

  task automatic push(input string nm, input outs_t v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sbq.push_back(e);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [3:0] fl);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    {Zero, notZero, LessThan, GreaterEqual} = fl;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each sequence starts 1 time unit after the edge that enters FETCH.
  task automatic do_lw(input string nm);
    set_instr(7'b0000011, 3'b010, 1'b0, 4'b1111);
    push({nm, "_fetch"},   e_fetch(2'b00));
    push({nm, "_decode"},  e_decode(2'b00));
    push({nm, "_memadr"},  e_memadr(2'b00));
    push({nm, "_memread"}, e_memread(2'b00));
    push({nm, "_memwb"},   e_memwb(2'b00));
    run(5);
  endtask

  task automatic do_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic [1:0] srcb, input logic [2:0] alu);
    set_instr(o, f3, f7, 4'b1111);
    push({nm, "_fetch"},  e_fetch(2'b00));
    push({nm, "_decode"}, e_decode(2'b00));
    push({nm, "_exec"},   e_exec(srcb, 2'b00, alu));
    push({nm, "_aluwb"},  e_aluwb(2'b00));
    run(4);
  endtask

  task automatic do_jal();
    set_instr(7'b1101111, 3'b000, 1'b0, 4'b0000);
    push("jal_fetch",  e_fetch(2'b11));
    push("jal_decode", e_decode(2'b11));
    push("jal_jal",    e_jal());
    push("jal_aluwb",  e_aluwb(2'b11));
    run(4);
  endtask

  task automatic do_sw();
    set_instr(7'b0100011, 3'b010, 1'b0, 4'b1111);
    push("sw_fetch",    e_fetch(2'b01));
    push("sw_decode",   e_decode(2'b01));
    push("sw_memadr",   e_memadr(2'b01));
    push("sw_memwrite", e_memwrite(2'b01));
    run(4);
  endtask

  task automatic do_branch(input string nm, input logic [2:0] f3,
                           input logic [3:0] fl, input logic taken);
    set_instr(7'b1100011, f3, 1'b0, fl);
    push({nm, "_fetch"},  e_fetch(2'b10));
    push({nm, "_decode"}, e_decode(2'b10));
    push({nm, "_branch"}, e_branch(taken));
    run(3);
  endtask

  task automatic do_illegal(input logic [6:0] o);
    set_instr(o, 3'b000, 1'b0, 4'b1111);
    push("ill_fetch",  e_fetch(2'b00));
    push("ill_decode", e_decode_ill(2'b00));
    run(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_instr(7'b0000000, 3'b000, 1'b0, 4'b1111);

    // Reset held for three edges; outputs checked after the first.
    @(posedge clk);
    #1;
    push("reset_cyc2", e_reset(2'b00));
    push("reset_cyc3", e_reset(2'b00));
    run(2);
    reset = 1'b0;

    // The first lw FETCH is the cycle right after release.
    do_lw("lw");

    // R-type and I-type ALU decode (flags held high to show no effect).
    do_alu("sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
    do_alu("add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000);
    do_alu("slt",  7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
    do_alu("and",  7'b0110011, 3'b111, 1'b1, 2'b00, 3'b010);
    do_alu("ori",  7'b0010011, 3'b110, 1'b0, 2'b01, 3'b011);
    do_alu("addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
    do_alu("xor",  7'b0110011, 3'b100, 1'b0, 2'b00, 3'b000);

    do_jal();
    do_sw();

    // Flags order: {Zero, notZero, LessThan, GreaterEqual}
    do_branch("beq_t", 3'b000, 4'b1000, 1'b1);
    do_branch("beq_n", 3'b000, 4'b0111, 1'b0);
    do_branch("bne_t", 3'b001, 4'b0100, 1'b1);
    do_branch("bne_n", 3'b001, 4'b1011, 1'b0);
    do_branch("blt_t", 3'b100, 4'b0010, 1'b1);
    do_branch("blt_n", 3'b100, 4'b1101, 1'b0);
    do_branch("bge_t", 3'b101, 4'b0001, 1'b1);
    do_branch("bge_n", 3'b101, 4'b1110, 1'b0);
    do_branch("b_f3_010", 3'b010, 4'b1111, 1'b0);

    do_illegal(7'b1111111);

    // Reset landing in MEMWRITE: no write, FETCH selects, FETCH afterwards.
    set_instr(7'b0100011, 3'b010, 1'b0, 4'b1111);
    push("swr_fetch",  e_fetch(2'b01));
    push("swr_decode", e_decode(2'b01));
    push("swr_memadr", e_memadr(2'b01));
    run(3);
    reset = 1'b1;
    push("swr_reset_in_memwrite", e_reset(2'b01));
    run(1);
    reset = 1'b0;
    do_branch("after_rst", 3'b000, 4'b1000, 1'b1);

    run(2);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
